// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator.
// A shared prescaler produces a one-cycle step tick. A mode-selected pattern
// state (count, scan, breathe or static) drives the LEDs through a global PWM
// gate that sets brightness.
// Build option: define LED_GAMMA_EN to give breathe mode a square-law duty
// curve. When it is undefined, breathe duty follows level linearly.
module led_pattern_gen #(
  parameter int CHANNELS      = 8,
  parameter int PRESCALE_BITS = 23,
  parameter int PWM_BITS      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] pattern_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int POS_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    M_COUNT   = 2'b00,
    M_SCAN    = 2'b01,
    M_BREATHE = 2'b10,
    M_STATIC  = 2'b11
  } mode_e;

  logic [PRESCALE_BITS-1:0] prescaler;
  logic [CHANNELS-1:0]      cnt;
  logic [POS_W-1:0]         pos;
  logic [POS_W-1:0]         pos_nxt;
  logic                     pos_up;
  logic [PWM_BITS-1:0]      level;
  logic [PWM_BITS-1:0]      level_nxt;
  logic                     level_up;
  logic [PWM_BITS-1:0]      pwm_cnt;
  mode_e                    mode_q;

  logic [CHANNELS-1:0]      raw;
  logic [PWM_BITS-1:0]      duty;
  logic [PWM_BITS-1:0]      breathe_duty;
  logic                     on;

  // Free-running prescaler. Tick is registered, so it goes high for the one
  // cycle that follows prescaler reaching all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
      tick      <= 1'b0;
    end else begin
      prescaler <= prescaler + PRESCALE_BITS'(1);
      tick      <= &prescaler;
    end
  end

  // Bouncing sequences. The direction flips on the step that lands on an end
  // point, so neither end is held for more than one tick.
  assign pos_nxt   = pos_up   ? pos + POS_W'(1)      : pos - POS_W'(1);
  assign level_nxt = level_up ? level + PWM_BITS'(1) : level - PWM_BITS'(1);

  // Pattern state. A mode change restarts the pattern and takes priority over
  // a tick on the same edge. The prescaler is not affected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      pos      <= '0;
      pos_up   <= 1'b1;
      level    <= '0;
      level_up <= 1'b1;
      mode_q   <= mode_e'(mode);
    end else begin
      mode_q <= mode_e'(mode);
      if (mode_e'(mode) != mode_q) begin
        cnt      <= '0;
        pos      <= '0;
        pos_up   <= 1'b1;
        level    <= '0;
        level_up <= 1'b1;
      end else if (tick) begin
        case (mode_q)
          M_COUNT: cnt <= cnt + CHANNELS'(1);
          M_SCAN: begin
            pos <= pos_nxt;
            if (pos_nxt == POS_W'(CHANNELS - 1)) pos_up <= 1'b0;
            else if (pos_nxt == '0)              pos_up <= 1'b1;
          end
          M_BREATHE: begin
            level <= level_nxt;
            if (&level_nxt)              level_up <= 1'b0;
            else if (level_nxt == '0)    level_up <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq     = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
  // The square law alone cannot reach all-ones, so the peak is forced fully on.
  assign breathe_duty = (&level) ? '1 : PWM_BITS'(level_sq >> PWM_BITS);
`else
  assign breathe_duty = level;
`endif

  // Raw pattern and duty select. Breathe mode ignores the brightness input.
  always_comb begin
    raw  = '0;
    duty = brightness;
    case (mode_q)
      M_COUNT:   raw = cnt;
      M_SCAN:    raw = CHANNELS'(1) << pos;
      M_BREATHE: begin
        raw  = '1;
        duty = breathe_duty;
      end
      M_STATIC:  raw = pattern_in;
      default:   raw = '0;
    endcase
  end

  // All-ones duty is treated as always on. A compare alone would leave one
  // off cycle per PWM period.
  assign on = (&duty) | (pwm_cnt < duty);

  // PWM phase counter and the registered, gated LED drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led     <= raw & {CHANNELS{on}};
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (CHANNELS=8, PRESCALE_BITS=3,
// PWM_BITS=4). The expected LED word is derived from the clock count since
// reset and the number of steps since the last restart.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] pattern_in = 8'h00;
  logic [3:0] brightness = 4'h0;
  logic       tick;
  logic [7:0] led;

  led_pattern_gen #(
    .CHANNELS(8),
    .PRESCALE_BITS(3),
    .PWM_BITS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .pattern_in(pattern_in),
    .brightness(brightness),
    .tick(tick),
    .led(led)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: clock edges since reset, steps since the last restart,
  // and the mode value the design has registered.
  int m  = 0;
  int k  = 0;
  int mq = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, m);
  endtask

  // Bounce position after kk steps of a 0..top..0 sequence with no dwell at the ends.
  function automatic int bounce(input int kk, input int top);
    int p;
    p = kk % (2 * top);
    return (p <= top) ? p : 2 * top - p;
  endfunction

  function automatic int exp_led(input int md, input int kk, input int pat,
                                 input int br, input int pwm);
    int raw;
    int duty;
    int lvl;
    raw  = 0;
    duty = br;
    case (md)
      0: raw = kk % 256;
      1: raw = 1 << bounce(kk, 7);
      2: begin
        raw = 255;
        lvl = bounce(kk, 15);
`ifdef LED_GAMMA_EN
        duty = (lvl == 15) ? 15 : (lvl * lvl) / 16;
`else
        duty = lvl;
`endif
      end
      default: raw = pat;
    endcase
    return (duty == 15 || pwm < duty) ? raw : 0;
  endfunction

  // One clock: drive at negedge, advance the reference, check after posedge.
  task automatic step(input logic r, input logic [1:0] md, input logic [7:0] pat,
                      input logic [3:0] br);
    int  e_led;
    int  e_tick;
    bit  tick_now;
    @(negedge clk);
    rst_n      = r;
    mode       = md;
    pattern_in = pat;
    brightness = br;
    if (!r) begin
      e_led  = 0;
      e_tick = 0;
      m      = 0;
      k      = 0;
      mq     = int'(md);
    end else begin
      tick_now = (m > 0) && (m % 8 == 0);
      e_led    = exp_led(mq, k, int'(pat), int'(br), m % 16);
      if (int'(md) != mq) k = 0;
      else if (tick_now)  k++;
      mq     = int'(md);
      m++;
      e_tick = (m % 8 == 0) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("led", 32'(led), 32'(e_led));
    chk("tick", 32'(tick), 32'(e_tick));
  endtask

  function automatic logic [3:0] pick_br();
    case ($urandom_range(0, 3))
      0:       return 4'd0;
      1:       return 4'd15;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic [1:0] md;
    logic [3:0] br;
    logic [7:0] pat;
    int         len;

    // Reset for 3 clocks, then count mode at full brightness through a wrap.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 8'h00, 4'd15);
    for (int i = 0; i < 2100; i++) step(1'b1, 2'b00, 8'h00, 4'd15);

    // Scan through several bounces.
    for (int i = 0; i < 130; i++) step(1'b1, 2'b01, 8'h00, 4'd15);

    // Static pattern at duty 4, then duty 0, then full.
    for (int i = 0; i < 64; i++) step(1'b1, 2'b11, 8'hA5, 4'd4);
    for (int i = 0; i < 32; i++) step(1'b1, 2'b11, 8'hA5, 4'd0);
    for (int i = 0; i < 32; i++) step(1'b1, 2'b11, 8'hA5, 4'd15);

    // A full breathe cycle.
    for (int i = 0; i < 260; i++) step(1'b1, 2'b10, 8'h00, 4'd7);

    // Scan to position 2 with a tick due, flip to count on that edge, then back.
    step(1'b1, 2'b00, 8'h00, 4'd15);
    for (int i = 0; i < 300 && !(mq == 1 && k == 2 && m % 8 == 0); i++)
      step(1'b1, 2'b01, 8'h00, 4'd15);
    step(1'b1, 2'b00, 8'h00, 4'd15);
    step(1'b1, 2'b01, 8'h00, 4'd15);
    for (int i = 0; i < 60; i++) step(1'b1, 2'b01, 8'h00, 4'd15);

    // Reset in the middle of a breathe cycle.
    for (int i = 0; i < 100; i++) step(1'b1, 2'b10, 8'h00, 4'd15);
    step(1'b0, 2'b10, 8'h00, 4'd15);
    for (int i = 0; i < 60; i++) step(1'b1, 2'b10, 8'h00, 4'd15);

    // Random phases with occasional resets and mode glitches.
    for (int ph = 0; ph < 60; ph++) begin
      md  = 2'($urandom_range(0, 3));
      br  = pick_br();
      pat = 8'($urandom);
      len = int'($urandom_range(1, 150));
      if ($urandom_range(0, 7) == 0)
        for (int i = 0; i < int'($urandom_range(1, 2)); i++) step(1'b0, md, pat, br);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 40) == 0) step(1'b1, 2'($urandom_range(0, 3)), pat, br);
        else begin
          if (md == 2'b11 && $urandom_range(0, 9) == 0) pat = 8'($urandom);
          step(1'b1, md, pat, br);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
